bcd_to_bin_decoder: RTL and testbench
=====================================

// Module: bcd_to_bin_decoder
// PURPOSE
//   Sequential BCD-to-binary decoder: the consumer end of the BCD counter path.
//   Takes one packed DIGITS-digit BCD word per valid/ready handshake.
//   Converts it by reverse double-dabble: shift right 1 bit per cycle, then subtract 3 from any digit >= 8.
//   Returns the unsigned binary value on a second valid/ready handshake.
//   Also flags any non-decimal input digit.
// PARAMETERS
//   DIGITS  4   number of BCD digits in bcd_in (4 bits each)
//   BIN_W   14  output width; must satisfy 2**BIN_W > 10**DIGITS - 1
// PORTS
//   clk        in   1         single clock, rising edge
//   rst        in   1         asynchronous reset, ACTIVE-LOW (0 = reset)
//   in_valid   in   1         bcd_in holds a word to convert
//   in_ready   out  1         block can accept a word (IDLE only)
//   bcd_in     in   4*DIGITS  packed BCD, digit 0 in [3:0]
//   out_valid  out  1         out_bin/err hold a finished result
//   out_ready  in   1         downstream takes the result
//   out_bin    out  BIN_W     binary value of bcd_in
//   err        out  1         some input digit was > 9 (out_bin forced to 0)
// BEHAVIOUR
//   Reset (rst=0, any time, asynchronous): state=IDLE, in_ready=0 while rst=0, out_valid=0,
//     out_bin=0, err=0, shift regs and counter cleared. Reset mid-SHIFT or mid-DONE drops the
//     word silently; in_ready=1 from the first clk edge after rst deasserts.
//   States and transitions:
//     IDLE:  in_ready=1. On in_valid&&in_ready: load bcd_sr<=bcd_in, bin_sr<=0, cnt<=4*DIGITS-1,
//            latch err_r = OR over digits of (digit > 9); go to SHIFT.
//     SHIFT: each edge: {bcd_sr,bin_sr} >>= 1, then each 4-bit digit of bcd_sr: if >= 8, subtract 3.
//            cnt decrements. The edge with cnt==0 performs the last shift and goes to DONE.
//            That edge loads out_bin from bin_sr (low BIN_W bits after the final shift),
//            or 0 if err_r. It also loads err from err_r.
//     DONE:  out_valid=1, and out_bin/err are held stable until out_valid&&out_ready.
//            That edge returns to IDLE, sets out_valid=0 and leaves out_bin/err unchanged.
//   Latency: accept at edge k -> out_valid=1 after edge k+4*DIGITS (16 for DIGITS=4); no pipelining.
//   in_ready=0 in SHIFT and DONE. New inputs are ignored (not queued) while busy.
//   No same-cycle result-pop plus new accept: the next accept happens in IDLE at the earliest.
//   in_valid may drop without consequence while in_ready=0.
//   Widths: bin_sr is 4*DIGITS wide; bits above BIN_W are always 0 for valid input and discarded.
//   Digit correction never underflows, since it applies only to digits >= 8.
//   Invalid input: conversion still runs full length (fixed latency); result forced to 0, err=1.
// STRUCTURE
//   bcd_pkg: DIGIT_W=4, state encoding IDLE/SHIFT/DONE (2-bit localparams),
//     function is_bad_digit(4b) returning (d > 9).
//   One combinational sub-module, bcd_digit_adjust (4b in -> d>=8 ? d-3 : d).
//     Instantiated DIGITS times in a generate loop on the post-shift bcd_sr.
//   Everything else (FSM, counter of $clog2(4*DIGITS) bits, shift regs) lives in this module.
// TESTING
//   1 bcd_in=16'h0000 -> out_valid 16 edges after accept, out_bin=0, err=0.
//   2 bcd_in=16'h9999 -> out_bin=14'd9999 (14'h270F), err=0; also 16'h0042 -> 42, 16'h1000 -> 1000.
//   3 bcd_in=16'h00A5 -> out_bin=0, err=1, same 16-cycle latency; next word 16'h0007 -> 7, err=0.
//   4 out_ready=0 for 5 cycles in DONE -> out_valid, out_bin, err stable; in_ready=0;
//     in_valid pulses are ignored; out_ready=1 -> IDLE next edge.
//   5 rst=0 asserted at SHIFT cycle 8 -> all outputs 0 immediately (async);
//     after release, 16'h0123 -> 123 with no residue.
//   6 back-to-back: in_valid and out_ready held 1, 20 random valid words -> each result matches
//     the reference model; accepts spaced exactly 4*DIGITS+2 edges apart.

Source files
------------

// File: rtl/bcd_to_bin_decoder_pkg.sv
// Shared constants, state encoding and digit helpers for the BCD-to-binary decoder.
package bcd_to_bin_decoder_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // True when a 4-bit BCD digit holds a non-decimal code (10..15).
    function automatic logic is_bad_digit(input logic [DIGIT_W-1:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_to_bin_decoder_digit_adjust.sv
// One digit of the reverse double-dabble correction: after a right shift a digit
// that reads 8 or more received a half-ten from its upper neighbour, worth 5, not 8,
// so 3 is taken off. Digits below 8 pass through, so this can never underflow.
module bcd_to_bin_decoder_digit_adjust
    import bcd_to_bin_decoder_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/bcd_to_bin_decoder.sv
// Sequential BCD-to-binary decoder. Accepts a packed BCD word on one valid/ready
// handshake, shifts it into a binary register one bit per cycle with per-digit
// correction, and offers the binary value (or 0 plus err for non-decimal input)
// on a second valid/ready handshake. One word in flight at a time.
module bcd_to_bin_decoder
    import bcd_to_bin_decoder_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BIN_W-1:0]          out_bin,
    output logic                      err
);

    localparam int SR_W  = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(SR_W);

    state_e             state_q;
    logic [SR_W-1:0]    bcd_sr_q;
    logic [SR_W-1:0]    bin_sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_r_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [BIN_W-1:0]   out_bin_q;
    logic               err_q;

    logic [SR_W-1:0]    bcd_shift_d;
    logic [SR_W-1:0]    bcd_adj_d;
    logic [SR_W-1:0]    bin_shift_d;
    logic               bad_any_d;

    // One step of the combined right shift: the BCD LSB drops into the binary MSB.
    assign bcd_shift_d = bcd_sr_q >> 1;
    assign bin_shift_d = {bcd_sr_q[0], bin_sr_q[SR_W-1:1]};

    // Per-digit correction applied to the already-shifted BCD register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_to_bin_decoder_digit_adjust u_adj (
            .digit_i (bcd_shift_d[g*DIGIT_W +: DIGIT_W]),
            .digit_o (bcd_adj_d[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Flag a word that contains any non-decimal digit.
    always_comb begin
        // NOTE: a default before the loop keeps every path assigned, so no latch is inferred.
        bad_any_d = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (is_bad_digit(bcd_in[i*DIGIT_W +: DIGIT_W])) begin
                bad_any_d = 1'b1;
            end
        end
    end

    // Control FSM, shift registers, counter and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the shift registers are cleared too, so an aborted word leaves no residue.
            state_q     <= ST_IDLE;
            bcd_sr_q    <= '0;
            bin_sr_q    <= '0;
            cnt_q       <= '0;
            err_r_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        bcd_sr_q   <= bcd_in;
                        bin_sr_q   <= '0;
                        cnt_q      <= CNT_W'(SR_W - 1);
                        err_r_q    <= bad_any_d;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_sr_q <= bcd_adj_d;
                    bin_sr_q <= bin_shift_d;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        out_valid_q <= 1'b1;
                        out_bin_q   <= err_r_q ? '0 : bin_shift_d[BIN_W-1:0];
                        err_q       <= err_r_q;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin_decoder.sv
// Self-checking bench for bcd_to_bin_decoder (DIGITS=4, BIN_W=14): directed corner
// words, DONE back-pressure, asynchronous reset mid-conversion and a back-to-back
// random stream, all compared against a decimal-arithmetic reference model.
module tb_bcd_to_bin_decoder;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int LAT    = 4 * DIGITS;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd_in = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [BIN_W-1:0]    out_bin;
    logic                err;

    int n_vec  = 0;
    int n_fail = 0;
    int edge_cnt = 0;

    bcd_to_bin_decoder #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Reference: decimal weight of each nibble; any nibble above 9 makes the word invalid.
    function automatic void ref_model(input logic [4*DIGITS-1:0] w, output int val, output logic bad);
        int p;
        int d;
        p   = 1;
        val = 0;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'((w >> (4 * i)) & 16'hF);
            if (d > 9) bad = 1'b1;
            val += d * p;
            p *= 10;
        end
        if (bad) val = 0;
    endfunction

    function automatic logic [4*DIGITS-1:0] rand_word();
        logic [4*DIGITS-1:0] w;
        int d;
        w = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) d = int'($urandom_range(10, 15));
            w[4*i +: 4] = 4'(d);
        end
        return w;
    endfunction

    // Offer one word, check latency and result, hold DONE for `hold` cycles, then pop.
    // Entered and left 1 ns after a rising edge.
    task automatic convert(input logic [4*DIGITS-1:0] w, input int hold);
        int   lat;
        int   val;
        logic bad;
        int   tries;
        tries = 0;
        while (in_ready !== 1'b1 && tries < 40) begin
            @(posedge clk); #1;
            tries++;
        end
        check("in_ready_before_accept", in_ready, 1);
        ref_model(w, val, bad);
        in_valid = 1'b1;
        bcd_in   = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bcd_in   = 16'($urandom);
        check("in_ready_busy", in_ready, 0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, LAT);
        check("out_bin", 32'(out_bin), val);
        check("err", err, bad);
        check("in_ready_done", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            bcd_in   = 16'($urandom);
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_out_bin", 32'(out_bin), val);
            check("hold_err", err, bad);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("pop_out_valid", out_valid, 0);
        check("pop_out_bin_kept", 32'(out_bin), val);
        check("pop_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [4*DIGITS-1:0] exp_q[$];
        logic [4*DIGITS-1:0] w;
        int   val;
        logic bad;
        int   n_acc;
        int   n_res;
        int   last_acc;
        int   cyc;
        logic acc;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bin", 32'(out_bin), 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_in_ready_pre_edge", in_ready, 0);
        @(posedge clk); #1;
        check("rel_in_ready_post_edge", in_ready, 1);

        // Directed words.
        convert(16'h0000, 0);
        convert(16'h9999, 0);
        convert(16'h0042, 0);
        convert(16'h1000, 0);
        convert(16'h00A5, 0);
        convert(16'h0007, 0);

        // Back-pressure in DONE with in_valid pulses.
        convert(16'h3581, 5);

        // Asynchronous reset in the middle of SHIFT.
        in_valid = 1'b1;
        bcd_in   = 16'h9999;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_in_ready", in_ready, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_bin", 32'(out_bin), 0);
        check("async_rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rerel_in_ready", in_ready, 1);
        convert(16'h0123, 0);

        // Back-to-back random stream with in_valid and out_ready held high.
        n_acc    = 0;
        n_res    = 0;
        last_acc = -1;
        cyc      = 0;
        bcd_in    = rand_word();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (n_res < 20 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected_result", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    ref_model(w, val, bad);
                    check("b2b_out_bin", 32'(out_bin), val);
                    check("b2b_err", err, bad);
                end
                n_res++;
            end
            acc = in_valid && (in_ready === 1'b1);
            if (acc) begin
                exp_q.push_back(bcd_in);
                if (last_acc >= 0) check("b2b_accept_gap", edge_cnt - last_acc, LAT + 2);
                last_acc = edge_cnt;
                n_acc++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (n_acc == 20) in_valid = 1'b0;
                else bcd_in = rand_word();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", n_res, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
